// File: rtl/au_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : au_pkg
//  Description : Shared op codes, FSM states and sequencer flow codes for the
//                arithmetic unit.
//  Revision    : 1.0  initial release
// ============================================================================
package au_pkg;

    localparam logic [1:0] AU_ADD = 2'b00;
    localparam logic [1:0] AU_SUB = 2'b01;
    localparam logic [1:0] AU_MUL = 2'b10;
    localparam logic [1:0] AU_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DIV_RUN = 2'b01,
        ST_DONE    = 2'b10
    } au_state_e;

    // Sequencer flow codes; the unit's continue_o is consumed by FLOW_WAIT.
    localparam logic [1:0] FLOW_INC  = 2'b00;
    localparam logic [1:0] FLOW_WAIT = 2'b01;
    localparam logic [1:0] FLOW_HALT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/au_if.sv
`default_nettype none
// ============================================================================
//  Module      : au_if
//  Description : Sequencer/data-bank side bundle of the arithmetic unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface au_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0] opnd_s;
    logic [WIDTH-1:0] result;
    logic             continue_o;
    logic             busy;
    logic             ovf;
    logic             dz;
    logic             err_busy;

    modport master (
        output start, op, opnd_r, opnd_s,
        input  result, continue_o, busy, ovf, dz, err_busy
    );

    modport slave (
        input  start, op, opnd_r, opnd_s,
        output result, continue_o, busy, ovf, dz, err_busy
    );
endinterface
`default_nettype wire

// File: rtl/au_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : au_div_iter
//  Description : Restoring unsigned divider, one quotient bit per clock.
//  Revision    : 1.0  initial release
// ============================================================================
module au_div_iter
    import au_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    ld,
    input  wire logic [WIDTH+FRAC-1:0]   dividend,
    input  wire logic [WIDTH-1:0]        divisor,
    output logic                         done,
    output logic [WIDTH+FRAC-1:0]        quotient
);
    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [N-1:0]     r_quo;
    logic [CW-1:0]    r_count;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [N-1:0]     w_quo_next;
    logic             w_unused_bit;

    // r_quo shifts dividend bits out of the top while quotient bits enter below
    assign w_shift      = {r_rem, r_quo[N-1]};
    assign w_diff       = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge         = ~w_diff[WIDTH+1];
    assign w_rem_next   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next   = {r_quo[N-2:0], w_ge};
    assign w_unused_bit = w_diff[WIDTH];

    // Final quotient is presented one step early so the caller can capture it
    // on the same edge the counter reaches zero.
    assign done     = (r_count == CW'(1));
    assign quotient = w_quo_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_count <= '0;
        end else if (ld) begin
            r_rem   <= '0;
            r_dvs   <= divisor;
            r_quo   <= dividend;
            r_count <= CW'(N);
        end else if (r_count != '0) begin
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_count <= r_count - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/au_core.sv
`default_nettype none
// ============================================================================
//  Module      : au_core
//  Description : Q-format ADD/SUB/MUL/DIV unit for the START/WAIT sequencer.
//                Define AU_SAT_EN to saturate overflowed results.
//  Revision    : 1.0  initial release
// ============================================================================
module au_core
    import au_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    au_if.slave       bus
);
    localparam int N = WIDTH + FRAC;
    localparam logic [WIDTH-1:0] C_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    au_state_e        r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_cont;
    logic             r_busy;
    logic             r_ovf;
    logic             r_dz;
    logic             r_err;
    logic             r_neg;

    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_s;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_sh;
    logic [WIDTH-1:0]   w_ar_res;
    logic               w_ar_ovf;
    logic [WIDTH-1:0]   w_ar_fix;

    logic [WIDTH-1:0] w_mag_r;
    logic [WIDTH-1:0] w_mag_s;
    logic             w_div_ld;
    logic             w_div_done;
    logic [N-1:0]     w_quo;
    logic [N:0]       w_qs;
    logic             w_q_ovf;
    logic [WIDTH-1:0] w_q_fix;

    assign w_r = bus.opnd_r;
    assign w_s = bus.opnd_s;

    assign w_sum  = {w_r[WIDTH-1], w_r} + {w_s[WIDTH-1], w_s};
    assign w_dif  = {w_r[WIDTH-1], w_r} - {w_s[WIDTH-1], w_s};
    // Sign-extended operands make the low 2*WIDTH bits the exact signed product
    assign w_prod    = {{WIDTH{w_r[WIDTH-1]}}, w_r} * {{WIDTH{w_s[WIDTH-1]}}, w_s};
    assign w_prod_sh = $signed(w_prod) >>> FRAC;

    always_comb begin
        w_ar_res = '0;
        w_ar_ovf = 1'b0;
        case (bus.op)
            AU_ADD: begin
                w_ar_res = w_sum[WIDTH-1:0];
                w_ar_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            end
            AU_SUB: begin
                w_ar_res = w_dif[WIDTH-1:0];
                w_ar_ovf = w_dif[WIDTH] ^ w_dif[WIDTH-1];
            end
            AU_MUL: begin
                w_ar_res = w_prod_sh[WIDTH-1:0];
                w_ar_ovf = !((&w_prod_sh[2*WIDTH-1:WIDTH-1]) ||
                             !(|w_prod_sh[2*WIDTH-1:WIDTH-1]));
            end
            default: ;
        endcase
    end

    // Divider works on magnitudes; the most negative operand maps to 2^(WIDTH-1)
    assign w_mag_r  = w_r[WIDTH-1] ? (~w_r + WIDTH'(1)) : w_r;
    assign w_mag_s  = w_s[WIDTH-1] ? (~w_s + WIDTH'(1)) : w_s;
    assign w_div_ld = bus.start && (r_state != ST_DIV_RUN) &&
                      (bus.op == AU_DIV) && (w_s != '0);

    au_div_iter #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (w_div_ld),
        .dividend (N'(w_mag_r) << FRAC),
        .divisor  (w_mag_s),
        .done     (w_div_done),
        .quotient (w_quo)
    );

    assign w_qs    = r_neg ? ({(N+1){1'b0}} - {1'b0, w_quo}) : {1'b0, w_quo};
    assign w_q_ovf = !((&w_qs[N:WIDTH-1]) || !(|w_qs[N:WIDTH-1]));

`ifdef AU_SAT_EN
    logic w_ar_neg;

    always_comb begin
        w_ar_neg = 1'b0;
        case (bus.op)
            AU_ADD:  w_ar_neg = w_sum[WIDTH];
            AU_SUB:  w_ar_neg = w_dif[WIDTH];
            AU_MUL:  w_ar_neg = w_prod_sh[2*WIDTH-1];
            default: w_ar_neg = 1'b0;
        endcase
    end

    assign w_ar_fix = w_ar_ovf ? (w_ar_neg ? C_MIN_NEG : C_MAX_POS) : w_ar_res;
    assign w_q_fix  = w_q_ovf ? (w_qs[N] ? C_MIN_NEG : C_MAX_POS) : w_qs[WIDTH-1:0];
`else
    assign w_ar_fix = w_ar_res;
    assign w_q_fix  = w_qs[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_cont   <= 1'b0;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_err    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_cont <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_dz   <= 1'b0;
                        if (bus.op != AU_DIV) begin
                            r_result <= w_ar_fix;
                            r_ovf    <= w_ar_ovf;
                            r_cont   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else if (w_s == '0) begin
                            r_result <= w_r[WIDTH-1] ? C_MIN_NEG : C_MAX_POS;
                            r_dz     <= 1'b1;
                            r_ovf    <= 1'b1;
                            r_cont   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_neg   <= w_r[WIDTH-1] ^ w_s[WIDTH-1];
                            r_busy  <= 1'b1;
                            r_state <= ST_DIV_RUN;
                        end
                    end
                end
                ST_DIV_RUN: begin
                    if (bus.start) begin
                        r_err <= 1'b1;
                    end
                    if (w_div_done) begin
                        r_result <= w_q_fix;
                        r_ovf    <= w_q_ovf;
                        r_cont   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result     = r_result;
    assign bus.continue_o = r_cont;
    assign bus.busy       = r_busy;
    assign bus.ovf        = r_ovf;
    assign bus.dz         = r_dz;
    assign bus.err_busy   = r_err;

endmodule
`default_nettype wire
